// File: rtl/sprite_mover.sv
// Sprite origin generator: moves the sprite diagonally once per update
// during vertical blank and bounces it off the active-area edges.
module sprite_mover #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SPRITE_SIZE = 8,
    parameter int START_X     = 100,
    parameter int START_Y     = 100,
    parameter int STEP        = 1,
    parameter int FRAME_DIV   = 1
) (
    input  logic        i_pix_clk,
    input  logic        i_reset,
    input  logic [15:0] i_horz_coord,
    input  logic [15:0] i_vert_coord,
    input  logic        i_enable,
    output logic [15:0] o_x_coord,
    output logic [15:0] o_y_coord,
    output logic        o_frame_tick,
    output logic        o_bounce
);

    localparam logic [16:0] X_MAX  = 17'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [16:0] Y_MAX  = 17'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [16:0] STEP17 = 17'(STEP);
    localparam logic [15:0] STEP16 = 16'(STEP);
    localparam logic [15:0] V_EVT  = 16'(V_ACTIVE);
    localparam logic [15:0] X_RST  = 16'(START_X);
    localparam logic [15:0] Y_RST  = 16'(START_Y);
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        MOVE_X,
        MOVE_Y,
        DONE
    } state_t;

    state_t        state_q;
    logic [15:0]   x_q;
    logic [15:0]   y_q;
    logic          dir_x_q;
    logic          dir_y_q;
    logic [CW-1:0] cnt_q;
    logic          match_q;
    logic          tick_q;
    logic          bounce_q;
    logic          flip_x_q;
    logic          flip_y_q;

    logic          match;
    logic          frame_evt;
    logic [15:0]   x_d;
    logic [15:0]   y_d;
    logic          flip_x_d;
    logic          flip_y_d;

    // Returns {flip, next_pos}; 17-bit compare so pos+STEP cannot wrap.
    function automatic logic [16:0] axis_step(
        input logic [15:0] pos,
        input logic        dir,
        input logic [16:0] pmax
    );
        logic [16:0] sum;
        logic [16:0] res;
        sum = {1'b0, pos} + STEP17;
        if (dir) begin
            if (sum >= pmax) res = {1'b1, pmax[15:0]};
            else             res = {1'b0, sum[15:0]};
        end else begin
            if ({1'b0, pos} <= STEP17) res = {1'b1, 16'd0};
            else                       res = {1'b0, pos - STEP16};
        end
        return res;
    endfunction

    // The vblank line spans many cycles; only the first match is an event.
    assign match     = (i_vert_coord == V_EVT) && (i_horz_coord == 16'd0);
    assign frame_evt = match && !match_q;

    always_comb begin
        {flip_x_d, x_d} = axis_step(x_q, dir_x_q, X_MAX);
        {flip_y_d, y_d} = axis_step(y_q, dir_y_q, Y_MAX);
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            state_q  <= WAIT_FRAME;
            x_q      <= X_RST;
            y_q      <= Y_RST;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            tick_q   <= 1'b0;
            bounce_q <= 1'b0;
            flip_x_q <= 1'b0;
            flip_y_q <= 1'b0;
        end else begin
            match_q  <= match;
            tick_q   <= frame_evt;
            bounce_q <= 1'b0;
            unique case (state_q)
                WAIT_FRAME: begin
                    if (frame_evt) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (i_enable) state_q <= MOVE_X;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                MOVE_X: begin
                    x_q      <= x_d;
                    flip_x_q <= flip_x_d;
                    if (flip_x_d) dir_x_q <= ~dir_x_q;
                    state_q  <= MOVE_Y;
                end
                MOVE_Y: begin
                    y_q      <= y_d;
                    flip_y_q <= flip_y_d;
                    if (flip_y_d) dir_y_q <= ~dir_y_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    bounce_q <= flip_x_q | flip_y_q;
                    state_q  <= WAIT_FRAME;
                end
                default: state_q <= WAIT_FRAME;
            endcase
        end
    end

    assign o_x_coord    = x_q;
    assign o_y_coord    = y_q;
    assign o_frame_tick = tick_q;
    assign o_bounce     = bounce_q;

endmodule
